tlb_l2_arbiter: RTL and testbench
=================================

# tlb_l2_arbiter

Shares the single L2 TLB search port between the instruction-side and data-side tcache miss paths. Each requester presents a miss (vppn, asid) and receives one hit/index response. Arbitration is round-robin with cancel support, and lookups are blocked or replayed while a TLB write or invalidate is in flight. The block sits between the two tcache miss state machines and the L2 TLB search port, inside the MMU top.

## Interface
Parameters:
- TLBIDLEN, default 4: L2 TLB index width; must match the L2 array.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req0_valid  in  1  inst-side miss request
- req0_vppn  in  19  inst-side VA[31:13]
- req0_asid  in  10  inst-side ASID
- req0_ready  out  1  inst request accepted this cycle
- cancel0  in  1  inst requester abandons its outstanding request
- resp0_valid  out  1  inst response strobe, one cycle
- resp0_hit  out  1  L2 hit for the inst request
- resp0_index  out  TLBIDLEN  L2 hit index for the inst request
- req1_valid, req1_vppn, req1_asid, req1_ready, cancel1, resp1_valid, resp1_hit, resp1_index: same as the port-0 signals, for the data side
- maint_active  in  1  a TLB write (we) or invtlb_valid is active this cycle
- l2_vppn  out  19  vppn driven to the L2 search port
- l2_asid  out  10  asid driven to the L2 search port
- l2_hit  in  1  combinational L2 hit for l2_vppn/l2_asid
- l2_index  in  TLBIDLEN  combinational L2 hit index

## Operation
- State machine: IDLE, LOOKUP, RESP. Internal registers: owner (0 or 1), rr_ptr (1 bit), latched vppn/asid, hit register, index register.
- IDLE:
  - If maint_active=1, grant nothing.
  - Otherwise, if exactly one reqN_valid is set, grant N.
  - If both are set, grant rr_ptr.
  - On a grant: reqN_ready=1 combinationally this cycle; latch vppn/asid into l2_vppn/l2_asid; set owner<=N and rr_ptr<=~N; go to LOOKUP.
- LOOKUP:
  - If cancel(owner)=1, go to IDLE with no response. Cancel takes priority over maint_active.
  - Else if maint_active=1, stay in LOOKUP and do not sample. This replays the lookup so a stale entry is never returned.
  - Otherwise, sample l2_hit/l2_index into the response registers and go to RESP.
- RESP:
  - resp(owner)_valid=1 with the registered hit/index, unless cancel(owner)=1 this cycle, in which case the strobe is suppressed.
  - Always go to IDLE next.
- resp_hit/resp_index of the non-owner hold their last value. Consumers qualify them with resp_valid only.
- reqN_ready is never asserted outside IDLE.
- A requester holds req_valid and its vppn/asid until ready. It must not raise a new request for the same side before its response or its cancel.
- cancel for a requester that does not own the active lookup is ignored.

## Timing
- Reset (async):
  - state=IDLE, rr_ptr=0 (inst side wins the first tie), owner=0.
  - l2_vppn=0, l2_asid=0, all resp*_valid/hit/index=0.
  - req*_ready=0 while reset is asserted.
- Reset mid-lookup drops the request silently. Requesters restart from their own reset.
- Minimum latency: grant in cycle t, sample at t+1, resp_valid at t+2. Next grant is possible at t+3.
- Each maint_active cycle during LOOKUP adds one cycle of latency.
- l2_vppn/l2_asid change only on a grant, so the L2 inputs are stable throughout LOOKUP.
- Simultaneous request and maint_active in IDLE: no grant. The request waits with req_valid held.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.

## Test plan
- Single inst miss: req0_valid=1, vppn=19'h12345, asid=10'h3, L2 returns hit=1, index=5 → req0_ready at t, resp0_valid at t+2 with hit=1 and index=5; resp1_valid stays 0.
- Contention: both requesters valid from reset with vppn 19'h1 and 19'h2 → first grant goes to port 0, l2_vppn=19'h1. Port 1 is granted at t+3 with l2_vppn=19'h2. Sustained valid on both gives alternating grants.
- Maintenance replay: maint_active=1 for 2 cycles entering LOOKUP, with l2_hit changing from 1 to 0 during them → response at t+4 carries hit=0 (the post-maintenance value).
- Cancel: cancel1=1 in LOOKUP → no resp1_valid; state returns to IDLE and a pending req0 is granted next cycle. A cancel asserted in RESP suppresses the strobe.
- Miss: L2 hit=0, index=0 → resp_valid with hit=0.
- Async reset asserted during RESP → resp_valid drops immediately, all outputs return to 0, and the next grant goes to port 0.

Source files
------------

// File: rtl/tlb_l2_arbiter.sv
// Round-robin arbiter sharing the L2 TLB search port between the
// instruction-side and data-side tcache miss paths, with cancel and maintenance replay.
module tlb_l2_arbiter #(
    parameter int TLBIDLEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [18:0]         req0_vppn,
    input  logic [9:0]          req0_asid,
    output logic                req0_ready,
    input  logic                cancel0,
    output logic                resp0_valid,
    output logic                resp0_hit,
    output logic [TLBIDLEN-1:0] resp0_index,
    input  logic                req1_valid,
    input  logic [18:0]         req1_vppn,
    input  logic [9:0]          req1_asid,
    output logic                req1_ready,
    input  logic                cancel1,
    output logic                resp1_valid,
    output logic                resp1_hit,
    output logic [TLBIDLEN-1:0] resp1_index,
    input  logic                maint_active,
    output logic [18:0]         l2_vppn,
    output logic [9:0]          l2_asid,
    input  logic                l2_hit,
    input  logic [TLBIDLEN-1:0] l2_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                rr_q, rr_d;
    logic [18:0]         vppn_q, vppn_d;
    logic [9:0]          asid_q, asid_d;
    logic                hit0_q, hit0_d;
    logic                hit1_q, hit1_d;
    logic [TLBIDLEN-1:0] idx0_q, idx0_d;
    logic [TLBIDLEN-1:0] idx1_q, idx1_d;
    logic                grant;
    logic                grant_id;
    logic                own_cancel;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        vppn_d     = vppn_q;
        asid_d     = asid_q;
        hit0_d     = hit0_q;
        hit1_d     = hit1_q;
        idx0_d     = idx0_q;
        idx1_d     = idx1_q;
        grant      = 1'b0;
        grant_id   = (req0_valid && req1_valid) ? rr_q : req1_valid;
        own_cancel = owner_q ? cancel1 : cancel0;
        unique case (state_q)
            S_IDLE: begin
                if (!maint_active && (req0_valid || req1_valid)) begin
                    grant   = 1'b1;
                    state_d = S_LOOKUP;
                    owner_d = grant_id;
                    rr_d    = ~grant_id;
                    vppn_d  = grant_id ? req1_vppn : req0_vppn;
                    asid_d  = grant_id ? req1_asid : req0_asid;
                end
            end
            S_LOOKUP: begin
                // Cancel wins; maintenance holds off sampling so no stale hit escapes
                if (own_cancel) begin
                    state_d = S_IDLE;
                end else if (!maint_active) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        hit1_d = l2_hit;
                        idx1_d = l2_index;
                    end else begin
                        hit0_d = l2_hit;
                        idx0_d = l2_index;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            vppn_q  <= '0;
            asid_q  <= '0;
            hit0_q  <= 1'b0;
            hit1_q  <= 1'b0;
            idx0_q  <= '0;
            idx1_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            vppn_q  <= vppn_d;
            asid_q  <= asid_d;
            hit0_q  <= hit0_d;
            hit1_q  <= hit1_d;
            idx0_q  <= idx0_d;
            idx1_q  <= idx1_d;
        end
    end

    assign req0_ready  = grant && !grant_id && !reset;
    assign req1_ready  = grant && grant_id && !reset;
    assign resp0_valid = (state_q == S_RESP) && !owner_q && !cancel0;
    assign resp1_valid = (state_q == S_RESP) && owner_q && !cancel1;
    assign resp0_hit   = hit0_q;
    assign resp0_index = idx0_q;
    assign resp1_hit   = hit1_q;
    assign resp1_index = idx1_q;
    assign l2_vppn     = vppn_q;
    assign l2_asid     = asid_q;

endmodule

// File: tb/tb_tlb_l2_arbiter.sv
// Directed testbench for tlb_l2_arbiter: grant, contention, replay,
// cancel, miss and async reset scenarios with hand-computed expectations.
module tb_tlb_l2_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [18:0]  req0_vppn, req1_vppn;
    logic [9:0]   req0_asid, req1_asid;
    logic         req0_ready, req1_ready;
    logic         cancel0, cancel1;
    logic         resp0_valid, resp1_valid;
    logic         resp0_hit, resp1_hit;
    logic [W-1:0] resp0_index, resp1_index;
    logic         maint_active;
    logic [18:0]  l2_vppn;
    logic [9:0]   l2_asid;
    logic         l2_hit;
    logic [W-1:0] l2_index;

    int n_checks = 0;
    int n_fail   = 0;

    tlb_l2_arbiter #(.TLBIDLEN(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_vppn(req0_vppn),
        .req0_asid(req0_asid), .req0_ready(req0_ready),
        .cancel0(cancel0), .resp0_valid(resp0_valid),
        .resp0_hit(resp0_hit), .resp0_index(resp0_index),
        .req1_valid(req1_valid), .req1_vppn(req1_vppn),
        .req1_asid(req1_asid), .req1_ready(req1_ready),
        .cancel1(cancel1), .resp1_valid(resp1_valid),
        .resp1_hit(resp1_hit), .resp1_index(resp1_index),
        .maint_active(maint_active),
        .l2_vppn(l2_vppn), .l2_asid(l2_asid),
        .l2_hit(l2_hit), .l2_index(l2_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; land 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_vppn = 0; req1_vppn = 0;
        req0_asid = 0; req1_asid = 0;
        cancel0 = 0; cancel1 = 0;
        maint_active = 0; l2_hit = 0; l2_index = 0;

        // Reset state, ready held low while in reset
        req0_valid = 1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_resp0", resp0_valid, 0);
        chk("rst_vppn", l2_vppn, 0);
        chk("rst_idx1", resp1_index, 0);
        req0_valid = 0;
        tick();
        tick();
        reset = 0;
        tick();

        // Single inst miss with L2 hit
        req0_valid = 1; req0_vppn = 19'h12345; req0_asid = 10'h3;
        l2_hit = 1; l2_index = 5;
        #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        #1;
        chk("t1_vppn", l2_vppn, 19'h12345);
        chk("t1_asid", l2_asid, 10'h3);
        chk("t1_lk_ready0", req0_ready, 0);
        chk("t1_lk_resp0", resp0_valid, 0);
        tick();
        l2_hit = 0; l2_index = 0;
        #1;
        chk("t1_resp0", resp0_valid, 1);
        chk("t1_hit0", resp0_hit, 1);
        chk("t1_idx0", resp0_index, 5);
        chk("t1_resp1", resp1_valid, 0);
        tick();
        chk("t1_idle_resp0", resp0_valid, 0);

        // Miss on the inst side
        req0_valid = 1; req0_vppn = 19'h00abc;
        #1;
        chk("miss_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        tick();
        #1;
        chk("miss_resp0", resp0_valid, 1);
        chk("miss_hit0", resp0_hit, 0);
        chk("miss_idx0", resp0_index, 0);
        tick();

        // Maintenance blocks a grant in IDLE, then replays LOOKUP
        req1_valid = 1; req1_vppn = 19'h7; req1_asid = 10'h55;
        maint_active = 1;
        #1;
        chk("mt_nogrant", req1_ready, 0);
        tick();
        maint_active = 0;
        #1;
        chk("mt_grant1", req1_ready, 1);
        tick();
        req1_valid = 0; maint_active = 1; l2_hit = 1; l2_index = 9;
        #1;
        chk("mt_vppn", l2_vppn, 19'h7);
        tick();
        l2_hit = 0; l2_index = 2;
        #1;
        chk("mt_stall_resp1", resp1_valid, 0);
        tick();
        maint_active = 0;
        #1;
        chk("mt_sample_resp1", resp1_valid, 0);
        tick();
        chk("mt_resp1", resp1_valid, 1);
        chk("mt_hit1", resp1_hit, 0);
        chk("mt_idx1", resp1_index, 2);
        chk("mt_hold_hit0", resp0_hit, 0);
        tick();

        // Cancel in LOOKUP, pending req0 granted next cycle
        req1_valid = 1; req1_vppn = 19'h44;
        #1;
        chk("cn_grant1", req1_ready, 1);
        tick();
        req1_valid = 0; cancel1 = 1; cancel0 = 1;
        req0_valid = 1; req0_vppn = 19'h99;
        l2_hit = 1; l2_index = 7;
        #1;
        chk("cn_lk_ready0", req0_ready, 0);
        tick();
        cancel1 = 0; cancel0 = 0;
        #1;
        chk("cn_resp1", resp1_valid, 0);
        chk("cn_ready0", req0_ready, 1);
        tick();
        req0_valid = 0;
        #1;
        chk("cn_vppn", l2_vppn, 19'h99);
        tick();
        cancel0 = 1;
        #1;
        chk("cn_resp_supp", resp0_valid, 0);
        chk("cn_hit0_reg", resp0_hit, 1);
        tick();
        cancel0 = 0;

        // Contention from reset: alternating grants 0,1,0,1
        do_reset();
        l2_hit = 0; l2_index = 0;
        req0_valid = 1; req0_vppn = 19'h1;
        req1_valid = 1; req1_vppn = 19'h2;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk($sformatf("ct_ready0_%0d", g), req0_ready, (g % 2 == 0));
            chk($sformatf("ct_ready1_%0d", g), req1_ready, (g % 2 == 1));
            tick();
            chk($sformatf("ct_vppn_%0d", g), l2_vppn,
                (g % 2 == 0) ? 19'h1 : 19'h2);
            chk($sformatf("ct_lk_rdy_%0d", g), req0_ready | req1_ready, 0);
            tick();
            chk($sformatf("ct_resp_%0d", g),
                (g % 2 == 0) ? resp0_valid : resp1_valid, 1);
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // Async reset during RESP
        req0_valid = 1; req0_vppn = 19'h3ff; req0_asid = 10'h1;
        l2_hit = 1; l2_index = 4'hf;
        tick();
        req0_valid = 0;
        tick();
        chk("ar_resp0", resp0_valid, 1);
        reset = 1;
        #1;
        chk("ar_resp0_drop", resp0_valid, 0);
        chk("ar_hit0", resp0_hit, 0);
        chk("ar_idx0", resp0_index, 0);
        chk("ar_vppn", l2_vppn, 0);
        chk("ar_asid", l2_asid, 0);
        tick();
        reset = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("ar_ready0", req0_ready, 1);
        chk("ar_ready1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
